// File: rtl/host_loader_if.sv
// Bundles the host byte streams and the top_control load/run/readback ports of host_loader.
// master is the loader side; slave is the host/processor side that faces it.
interface host_loader_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [15:0]       dram_in;
  logic              proc_done;
  logic [ADDR_W-1:0] addr_ext;
  logic [15:0]       Data_in_ins;
  logic [15:0]       Data_in_dram;
  logic              iram_write_ext;
  logic              dram_write_ext;
  logic              read_en_ext;
  logic              start;
  logic              start_2;
  logic              start_3;
  logic              start_4;

  modport master (
    input  rx_data, rx_valid, tx_ready, dram_in, proc_done,
    output rx_ready, tx_data, tx_valid, addr_ext, Data_in_ins, Data_in_dram,
           iram_write_ext, dram_write_ext, read_en_ext, start, start_2, start_3, start_4
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dram_in, proc_done,
    input  rx_ready, tx_data, tx_valid, addr_ext, Data_in_ins, Data_in_dram,
           iram_write_ext, dram_write_ext, read_en_ext, start, start_2, start_3, start_4
  );
endinterface

// File: rtl/host_loader.sv
// Byte-stream front end for top_control: loads IRAM/DRAM from a framed image, runs the
// processor, then streams the DRAM result window back out as bytes (MSB first).
module host_loader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int WR_CYCLES  = 4,
  parameter int RD_CYCLES  = 5,
  parameter int RUN_CYCLES = 120000
) (
  input  logic          clock,
  input  logic          reset,
  host_loader_if.master bus,
  output logic          busy,
  output logic          error,
  output logic [4:0]    state_dbg
);

  // Handshakes: a byte moves on rx (tx) only in a cycle where valid and ready are both
  // high at the rising edge; valid/data never depend on ready, and tx_valid/tx_data hold
  // unchanged until the byte is taken.

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    GET_NI   = 5'd1,
    I_BYTE   = 5'd2,
    I_SETUP  = 5'd3,
    I_WR     = 5'd4,
    I_HOLD   = 5'd5,
    I_GAP    = 5'd6,
    GET_ND   = 5'd7,
    D_BYTE   = 5'd8,
    D_SETUP  = 5'd9,
    D_WR     = 5'd10,
    D_HOLD   = 5'd11,
    GET_PAR  = 5'd12,
    RUN      = 5'd13,
    RUN_GAP  = 5'd14,
    RB_SETUP = 5'd15,
    RB_RD    = 5'd16,
    TX_HI    = 5'd17,
    TX_LO    = 5'd18,
    DONE     = 5'd19
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'((32'd1 << ADDR_W) - 32'd1);
  localparam logic [31:0] WR_LAST   = 32'(WR_CYCLES - 1);
  localparam logic [31:0] RD_LAST   = 32'(RD_CYCLES - 1);
  localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q;
  logic [7:0]          hi_q;
  logic [15:0]         words_left_q;
  logic                skip_q;
  logic [15:0]         addr_q;
  logic [31:0]         cnt_q;
  logic [DATA_W-1:0]   ins_q;
  logic [DATA_W-1:0]   dram_q;
  logic [DATA_W-1:0]   rd_q;
  logic [15:0]         fstart_q;
  logic [15:0]         fend_q;
  logic                error_q;

  logic                rx_ready;
  logic                rx_fire;
  logic                word_done;
  logic                par_done;
  logic [15:0]         rx_word;
  logic                iram_wr, dram_wr, rd_en, run;
  logic                mode_i, mode_d, mode_rb, tx_valid;

  assign rx_ready  = state_q inside {GET_NI, I_BYTE, GET_ND, D_BYTE, GET_PAR};
  assign rx_fire   = bus.rx_valid & rx_ready;
  assign word_done = rx_fire & byte_cnt_q[0];
  assign par_done  = rx_fire & (byte_cnt_q == 2'd3);
  assign rx_word   = {hi_q, bus.rx_data};

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    iram_wr  = 1'b0;
    dram_wr  = 1'b0;
    rd_en    = 1'b0;
    run      = 1'b0;
    mode_i   = 1'b0;
    mode_d   = 1'b0;
    mode_rb  = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_valid) state_d = GET_NI;
      GET_NI: begin
        mode_i = 1'b1;
        if (word_done) state_d = (rx_word == 16'd0) ? I_GAP : I_BYTE;
      end
      I_BYTE: begin
        mode_i = 1'b1;
        if (word_done) begin
          if (!skip_q)                    state_d = I_SETUP;
          else if (words_left_q == 16'd1) state_d = I_GAP;
        end
      end
      I_SETUP: begin
        mode_i  = 1'b1;
        state_d = I_WR;
      end
      I_WR: begin
        mode_i  = 1'b1;
        iram_wr = 1'b1;
        if (cnt_q == WR_LAST) state_d = I_HOLD;
      end
      I_HOLD: begin
        mode_i  = 1'b1;
        state_d = (words_left_q == 16'd1) ? I_GAP : I_BYTE;
      end
      // Both load modes low for this cycle so IRAM and DRAM modes never touch.
      I_GAP: state_d = GET_ND;
      GET_ND: begin
        mode_d = 1'b1;
        if (word_done) state_d = (rx_word == 16'd0) ? GET_PAR : D_BYTE;
      end
      D_BYTE: begin
        mode_d = 1'b1;
        if (word_done) begin
          if (!skip_q)                    state_d = D_SETUP;
          else if (words_left_q == 16'd1) state_d = GET_PAR;
        end
      end
      D_SETUP: begin
        mode_d  = 1'b1;
        state_d = D_WR;
      end
      D_WR: begin
        mode_d  = 1'b1;
        dram_wr = 1'b1;
        if (cnt_q == WR_LAST) state_d = D_HOLD;
      end
      D_HOLD: begin
        mode_d  = 1'b1;
        state_d = (words_left_q == 16'd1) ? GET_PAR : D_BYTE;
      end
      GET_PAR: if (par_done) state_d = RUN;
      RUN: begin
        run = 1'b1;
        if (bus.proc_done || cnt_q == RUN_LAST) state_d = RUN_GAP;
      end
      RUN_GAP: state_d = (fend_q > fstart_q) ? RB_SETUP : DONE;
      RB_SETUP: begin
        mode_rb = 1'b1;
        state_d = RB_RD;
      end
      RB_RD: begin
        mode_rb = 1'b1;
        rd_en   = 1'b1;
        if (cnt_q == RD_LAST) state_d = TX_HI;
      end
      TX_HI: begin
        mode_rb  = 1'b1;
        tx_valid = 1'b1;
        if (bus.tx_ready) state_d = TX_LO;
      end
      TX_LO: begin
        mode_rb  = 1'b1;
        tx_valid = 1'b1;
        if (bus.tx_ready) state_d = (addr_q + 16'd1 < fend_q) ? RB_SETUP : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q   <= '0;
      hi_q         <= '0;
      words_left_q <= '0;
      skip_q       <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      ins_q        <= '0;
      dram_q       <= '0;
      rd_q         <= '0;
      fstart_q     <= '0;
      fend_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      // cnt_q measures time spent in the current state.
      cnt_q <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
      if (!rx_ready) byte_cnt_q <= 2'd0;
      else if (rx_fire) begin
        hi_q       <= bus.rx_data;
        byte_cnt_q <= (state_q == GET_PAR) ? byte_cnt_q + 2'd1 : byte_cnt_q ^ 2'd1;
      end
      case (state_q)
        IDLE: if (bus.rx_valid) begin
          error_q <= 1'b0;
          skip_q  <= 1'b0;
        end
        GET_NI, GET_ND: if (word_done) begin
          words_left_q <= rx_word;
          addr_q       <= 16'd1;
          skip_q       <= (rx_word > MAX_WORDS);
          if (rx_word > MAX_WORDS) error_q <= 1'b1;
        end
        I_BYTE: if (word_done) begin
          if (skip_q) words_left_q <= words_left_q - 16'd1;
          else        ins_q <= rx_word;
        end
        D_BYTE: if (word_done) begin
          if (skip_q) words_left_q <= words_left_q - 16'd1;
          else        dram_q <= rx_word;
        end
        I_HOLD, D_HOLD: begin
          addr_q       <= addr_q + 16'd1;
          words_left_q <= words_left_q - 16'd1;
        end
        GET_PAR: if (rx_fire) begin
          if (byte_cnt_q == 2'd1) fstart_q <= rx_word;
          if (byte_cnt_q == 2'd3) fend_q   <= rx_word;
        end
        RUN: if (!bus.proc_done && cnt_q == RUN_LAST) error_q <= 1'b1;
        RUN_GAP: addr_q <= fstart_q;
        RB_RD: if (cnt_q == RD_LAST) rd_q <= bus.dram_in;
        TX_LO: if (bus.tx_ready) addr_q <= addr_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.tx_valid       = tx_valid;
  assign bus.tx_data        = (state_q == TX_HI) ? rd_q[15:8] :
                              (state_q == TX_LO) ? rd_q[7:0]  : 8'd0;
  assign bus.addr_ext       = addr_q[ADDR_W-1:0];
  assign bus.Data_in_ins    = ins_q;
  assign bus.Data_in_dram   = dram_q;
  assign bus.iram_write_ext = iram_wr;
  assign bus.dram_write_ext = dram_wr;
  assign bus.read_en_ext    = rd_en;
  assign bus.start          = run;
  assign bus.start_2        = mode_i;
  assign bus.start_3        = mode_d;
  assign bus.start_4        = mode_rb;

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_host_loader.sv
// Directed bench for host_loader: frame load, run handshake, readback, timeout,
// backpressure, length overflow and mid-write reset recovery.
module tb_host_loader;
  localparam int RUN_CYC = 300;
  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_I_WR = 5'd4;
  localparam logic [4:0] S_DONE = 5'd19;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy, error;
  logic [4:0] state_dbg;

  always #5 clock = ~clock;

  host_loader_if #(.ADDR_W(9)) bus ();

  host_loader #(
    .ADDR_W(9), .DATA_W(16), .WR_CYCLES(4), .RD_CYCLES(5), .RUN_CYCLES(RUN_CYC)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .error(error), .state_dbg(state_dbg)
  );

  // DRAM model: read data is the address times three.
  assign bus.dram_in = {7'd0, bus.addr_ext} * 16'd3;

  int n_cmp = 0;
  int n_fail = 0;
  int done_delay = 3;
  int run_seen = 0;
  int stall_left = 0;
  int stall_after = 0;
  bit stall_arm = 0;
  bit rx_abort = 0;
  logic [15:0] iw [8];
  logic [15:0] dw [8];

  logic [15:0] ia_q[$], id_q[$], da_q[$], dd_q[$];
  int          il_q[$], dl_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  int overlap_viol = 0, gap_viol = 0, start_viol = 0, s4_viol = 0;
  int stable_viol = 0, hold_viol = 0;
  int start_width = 0, s_len = 0, s3_cycles = 0, s4_cycles = 0, wait_cyc = 0;

  // Processor stand-in: raises proc_done after done_delay cycles of start (0 = never).
  always begin
    @(posedge clock); #1;
    if (bus.start) run_seen++; else run_seen = 0;
    bus.proc_done = (done_delay > 0) && bus.start && (run_seen >= done_delay);
  end

  always begin
    @(posedge clock); #1;
    if (stall_arm && tx_q.size() == stall_after) begin
      stall_arm  = 0;
      stall_left = 50;
    end
    if (stall_left > 0) begin
      bus.tx_ready = 1'b0;
      stall_left--;
    end else bus.tx_ready = 1'b1;
  end

  // Monitor: logs writes and tx bytes, counts ordering/stability violations.
  logic        iw_on = 0, dw_on = 0;
  logic [15:0] iw_a, iw_d, dw_a, dw_d;
  int          iw_len, dw_len;
  logic        p_s2 = 0, p_s3 = 0, p_s4 = 0, p_st = 0, p_txv = 0, p_txr = 0;
  logic [7:0]  p_txd = 0;
  always begin
    @(negedge clock);
    if (bus.iram_write_ext) begin
      if (iw_on) begin
        if (16'(bus.addr_ext) !== iw_a || bus.Data_in_ins !== iw_d) stable_viol++;
        iw_len++;
      end else begin
        iw_on = 1; iw_a = 16'(bus.addr_ext); iw_d = bus.Data_in_ins; iw_len = 1;
      end
    end else if (iw_on) begin
      iw_on = 0; ia_q.push_back(iw_a); id_q.push_back(iw_d); il_q.push_back(iw_len);
    end
    if (bus.dram_write_ext) begin
      if (dw_on) begin
        if (16'(bus.addr_ext) !== dw_a || bus.Data_in_dram !== dw_d) stable_viol++;
        dw_len++;
      end else begin
        dw_on = 1; dw_a = 16'(bus.addr_ext); dw_d = bus.Data_in_dram; dw_len = 1;
      end
    end else if (dw_on) begin
      dw_on = 0; da_q.push_back(dw_a); dd_q.push_back(dw_d); dl_q.push_back(dw_len);
    end
    if (bus.start_2 && bus.start_3) overlap_viol++;
    if (bus.start_3 && !p_s3 && p_s2) gap_viol++;
    if (bus.start && !p_st && (p_s2 || p_s3 || bus.start_2 || bus.start_3)) start_viol++;
    if (bus.start_4 && !p_s4 && (p_st || bus.start)) s4_viol++;
    if (bus.start) s_len++;
    else if (p_st) begin start_width = s_len; s_len = 0; end
    if (bus.start_3) s3_cycles++;
    if (bus.start_4) s4_cycles++;
    if (p_txv && !p_txr && (!bus.tx_valid || bus.tx_data !== p_txd)) hold_viol++;
    if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    if (bus.tx_valid && !bus.tx_ready) wait_cyc++;
    p_s2 = bus.start_2; p_s3 = bus.start_3; p_s4 = bus.start_4; p_st = bus.start;
    p_txv = bus.tx_valid; p_txr = bus.tx_ready; p_txd = bus.tx_data;
  end

  task automatic clear_logs();
    ia_q.delete(); id_q.delete(); il_q.delete();
    da_q.delete(); dd_q.delete(); dl_q.delete();
    tx_q.delete(); exp_q.delete();
    s3_cycles = 0; s4_cycles = 0; wait_cyc = 0; start_width = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if (rx_abort) return;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clock);
    while (!bus.rx_ready && t < 2000) begin @(negedge clock); t++; end
    if (!bus.rx_ready) begin
      n_cmp++; n_fail++; rx_abort = 1;
      $display("FAIL rx_accept: byte %02h not accepted within %0d cycles (state %0d)", b, t, state_dbg);
    end
    @(posedge clock); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_frame(input int ni, input int nd, input logic [15:0] fs, input logic [15:0] fe);
    send_word(16'(ni));
    for (int i = 0; i < ni; i++) send_word(iw[i % 8]);
    send_word(16'(nd));
    for (int i = 0; i < nd; i++) send_word(dw[i % 8]);
    send_word(fs);
    send_word(fe);
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (state_dbg !== S_DONE && t < budget) begin @(negedge clock); t++; end
    n_cmp++;
    if (state_dbg !== S_DONE) begin
      n_fail++;
      $display("FAIL %s_done: got state %0d, want %0d within %0d cycles", name, state_dbg, S_DONE, budget);
    end
    @(posedge clock); #1;
  endtask

  task automatic check_tx(input string name);
    n_cmp++;
    if (tx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_tx_count: got %0d bytes, want %0d", name, tx_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (tx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_tx[%0d]: got %02h, want %02h", name, i, tx_q[i], exp_q[i]);
        end
      end
  endtask

  task automatic check_idle(input string name, input logic exp_err);
    n_cmp++;
    if (state_dbg !== S_IDLE || busy !== 1'b0 || error !== exp_err) begin
      n_fail++;
      $display("FAIL %s_end: got state %0d busy %0b error %0b, want 0 0 %0b", name, state_dbg, busy, error, exp_err);
    end
  endtask

  task automatic test_reset();
    logic [10:0] flags;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    flags = {bus.rx_ready, bus.tx_valid, bus.iram_write_ext, bus.dram_write_ext, bus.read_en_ext,
             bus.start, bus.start_2, bus.start_3, bus.start_4, busy, error};
    n_cmp++;
    if (flags !== 11'd0) begin n_fail++; $display("FAIL reset_flags: got %011b, want 0", flags); end
    n_cmp++;
    if (bus.addr_ext !== 9'd0 || bus.tx_data !== 8'd0 || bus.Data_in_ins !== 16'd0 || bus.Data_in_dram !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_buses: got addr %0h tx %0h ins %0h dram %0h, want 0", bus.addr_ext, bus.tx_data, bus.Data_in_ins, bus.Data_in_dram);
    end
    n_cmp++;
    if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, want %0d", state_dbg, S_IDLE); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_load_readback();
    clear_logs();
    done_delay = 3;
    iw[0] = 16'h1234; iw[1] = 16'hABCD; dw[0] = 16'h0007;
    send_frame(2, 1, 16'd10, 16'd12);
    wait_done(3000, "load");
    n_cmp++;
    if (ia_q.size() != 2) begin n_fail++; $display("FAIL iram_count: got %0d, want 2", ia_q.size()); end
    else begin
      n_cmp++;
      if (ia_q[0] !== 16'd1 || id_q[0] !== 16'h1234 || il_q[0] != 4) begin
        n_fail++; $display("FAIL iram_w0: got a%0h d%0h len%0d, want a1 d1234 len4", ia_q[0], id_q[0], il_q[0]);
      end
      n_cmp++;
      if (ia_q[1] !== 16'd2 || id_q[1] !== 16'hABCD || il_q[1] != 4) begin
        n_fail++; $display("FAIL iram_w1: got a%0h d%0h len%0d, want a2 dabcd len4", ia_q[1], id_q[1], il_q[1]);
      end
    end
    n_cmp++;
    if (da_q.size() != 1) begin n_fail++; $display("FAIL dram_count: got %0d, want 1", da_q.size()); end
    else begin
      n_cmp++;
      if (da_q[0] !== 16'd1 || dd_q[0] !== 16'h0007 || dl_q[0] != 4) begin
        n_fail++; $display("FAIL dram_w0: got a%0h d%0h len%0d, want a1 d0007 len4", da_q[0], dd_q[0], dl_q[0]);
      end
    end
    n_cmp++;
    if (start_width != 3) begin n_fail++; $display("FAIL run_width: got %0d, want 3", start_width); end
    exp_q = '{8'h00, 8'h1E, 8'h00, 8'h21};
    check_tx("readback");
    check_idle("load", 1'b0);
  endtask

  task automatic test_mode_order();
    n_cmp++;
    if (overlap_viol != 0 || gap_viol != 0) begin
      n_fail++; $display("FAIL mode_overlap: got overlap %0d gap %0d, want 0 0", overlap_viol, gap_viol);
    end
    n_cmp++;
    if (start_viol != 0 || s4_viol != 0) begin
      n_fail++; $display("FAIL run_order: got start %0d start_4 %0d, want 0 0", start_viol, s4_viol);
    end
    n_cmp++;
    if (stable_viol != 0) begin n_fail++; $display("FAIL strobe_stable: got %0d changes, want 0", stable_viol); end
  endtask

  task automatic test_timeout();
    clear_logs();
    done_delay = 0;
    iw[0] = 16'h0001;
    send_frame(1, 0, 16'd5, 16'd6);
    wait_done(3000, "timeout");
    n_cmp++;
    if (start_width != RUN_CYC) begin n_fail++; $display("FAIL run_timeout_width: got %0d, want %0d", start_width, RUN_CYC); end
    n_cmp++;
    if (s3_cycles < 1 || da_q.size() != 0) begin
      n_fail++; $display("FAIL nd_zero: got start_3 cycles %0d dram writes %0d, want >=1 and 0", s3_cycles, da_q.size());
    end
    exp_q = '{8'h00, 8'h0F};
    check_tx("timeout");
    check_idle("timeout", 1'b1);
    done_delay = 3;
  endtask

  task automatic test_backpressure();
    clear_logs();
    stall_after = 1;
    stall_arm   = 1;
    send_frame(0, 0, 16'd3, 16'd5);
    wait_done(3000, "bp");
    stall_arm = 0;
    n_cmp++;
    if (wait_cyc != 50 || hold_viol != 0) begin
      n_fail++; $display("FAIL bp_hold: got wait %0d violations %0d, want 50 0", wait_cyc, hold_viol);
    end
    exp_q = '{8'h00, 8'h09, 8'h00, 8'h0C};
    check_tx("bp");
    check_idle("bp", 1'b0);
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int i = 0; i < 8; i++) iw[i] = 16'hFFFF;
    dw[0] = 16'h00AA;
    send_frame(512, 1, 16'd0, 16'd0);
    wait_done(1000, "ovf");
    n_cmp++;
    if (ia_q.size() != 0) begin n_fail++; $display("FAIL ovf_iram: got %0d writes, want 0", ia_q.size()); end
    n_cmp++;
    if (da_q.size() != 1 || dd_q[0] !== 16'h00AA || da_q[0] !== 16'd1) begin
      n_fail++; $display("FAIL ovf_dram: got %0d writes, want 1 at a1 d00aa", da_q.size());
    end
    check_idle("ovf", 1'b1);
  endtask

  task automatic test_reset_mid_write();
    int t = 0;
    clear_logs();
    send_word(16'd1);
    send_word(16'h5555);
    while (state_dbg !== S_I_WR && t < 20) begin @(negedge clock); t++; end
    n_cmp++;
    if (state_dbg !== S_I_WR) begin n_fail++; $display("FAIL mid_reach: got state %0d, want %0d", state_dbg, S_I_WR); end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.iram_write_ext !== 1'b0 || bus.start_2 !== 1'b0 || bus.addr_ext !== 9'd0 || state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL mid_reset: got wr %0b s2 %0b addr %0h state %0d, want 0 0 0 0", bus.iram_write_ext, bus.start_2, bus.addr_ext, state_dbg);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    clear_logs();
    iw[0] = 16'h0BEE; dw[0] = 16'h0F0F;
    send_frame(1, 1, 16'd7, 16'd7);
    wait_done(1000, "recover");
    n_cmp++;
    if (ia_q.size() != 1 || ia_q[0] !== 16'd1 || id_q[0] !== 16'h0BEE || il_q[0] != 4) begin
      n_fail++; $display("FAIL recover_iram: got %0d writes, want 1 at a1 d0bee len4", ia_q.size());
    end
    n_cmp++;
    if (da_q.size() != 1 || dd_q[0] !== 16'h0F0F) begin
      n_fail++; $display("FAIL recover_dram: got %0d writes, want 1 d0f0f", da_q.size());
    end
    n_cmp++;
    if (s4_cycles != 0) begin n_fail++; $display("FAIL empty_window: got start_4 cycles %0d, want 0", s4_cycles); end
    check_tx("recover");
    check_idle("recover", 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_mode_order();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_reset_mid_write();
    test_mode_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
